// File: rtl/bus_sel_pipe.sv
// ============================================================================
// Module   : bus_sel_pipe
// Purpose  : Registered one-of-N source selector (direct or round-robin scan)
//            with valid/ready output handshake and out-of-range select count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_sel_pipe #(
    parameter  int WIDTH   = 16,
    parameter  int NUM_SRC = 10,
    localparam int SEL_W   = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic                     req_valid,
    output logic                     req_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err,
    output logic [7:0]               err_cnt
);

    localparam logic [SEL_W-1:0] C_LAST_SRC = SEL_W'(NUM_SRC - 1);
    localparam logic [7:0]       C_ERR_MAX  = 8'hFF;

    logic [WIDTH-1:0] src_arr [NUM_SRC];

    logic             accept;
    logic             sel_ok;
    logic             load;
    logic [SEL_W-1:0] pick_idx;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [7:0]       err_cnt_q,   err_cnt_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
    end

    assign req_ready = !out_valid_q || out_ready;
    assign accept    = req_valid && req_ready;
    assign sel_ok    = (32'(sel) < NUM_SRC);
    assign pick_idx  = mode ? rr_ptr_q : sel;
    // Round-robin ignores sel entirely, so only direct mode can be rejected.
    assign load      = accept && (mode || sel_ok);

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        sel_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        rr_ptr_d    = rr_ptr_q;

        if (load) begin
            out_data_d  = src_arr[pick_idx];
            out_src_d   = pick_idx;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept && !mode && !sel_ok) begin
            sel_err_d = 1'b1;
            if (err_cnt_q != C_ERR_MAX) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        if (!mode) begin
            rr_ptr_d = '0;
        end else if (accept) begin
            rr_ptr_d = (rr_ptr_q == C_LAST_SRC) ? '0 : rr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            err_cnt_q   <= err_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_sel_pipe.sv
// ============================================================================
// Module   : tb_bus_sel_pipe
// Purpose  : Directed self-checking bench for bus_sel_pipe (16-bit, 10 sources).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_sel_pipe;

    localparam int WIDTH   = 16;
    localparam int NUM_SRC = 10;
    localparam int SEL_W   = 4;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel;
    logic                     mode;
    logic                     req_valid;
    logic                     req_ready;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_src;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sel_err;
    logic [7:0]               err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bus_sel_pipe #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src_data),
        .sel       (sel),
        .mode      (mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [WIDTH-1:0] v);
        src_data[idx*WIDTH +: WIDTH] = v;
    endtask

    task automatic load_default_src();
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'(16'h1000 + i));
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = '0;
        mode      = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b0;
        src_data  = '0;
        load_default_src();

        #2;
        chk_eq("rst_out_valid", 32'(out_valid), 32'h0);
        chk_eq("rst_out_data",  32'(out_data),  32'h0);
        chk_eq("rst_out_src",   32'(out_src),   32'h0);
        chk_eq("rst_err_cnt",   32'(err_cnt),   32'h0);
        chk_eq("rst_sel_err",   32'(sel_err),   32'h0);
        chk_eq("rst_req_ready", 32'(req_ready), 32'h1);
        step();
        step();
        rst_n = 1'b1;

        // Direct select
        mode = 1'b0; sel = 4'd3; req_valid = 1'b1; out_ready = 1'b1;
        step();
        chk_eq("dir_data",  32'(out_data),  32'h1003);
        chk_eq("dir_src",   32'(out_src),   32'h3);
        chk_eq("dir_valid", 32'(out_valid), 32'h1);

        // Backpressure: held word must not follow sel or source changes
        sel = 4'd5;
        step();
        chk_eq("bp_load", 32'(out_data), 32'h1005);
        out_ready = 1'b0; sel = 4'd7; set_src(5, 16'hBEEF);
        #1;
        chk_eq("bp_req_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_eq("bp_hold_data",  32'(out_data),  32'h1005);
            chk_eq("bp_hold_src",   32'(out_src),   32'h5);
            chk_eq("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        load_default_src();
        out_ready = 1'b1; req_valid = 1'b0;
        step();
        chk_eq("bp_drain_valid", 32'(out_valid), 32'h0);

        // Out-of-range selects
        req_valid = 1'b1; sel = 4'd12;
        step();
        chk_eq("bad12_sel_err", 32'(sel_err),   32'h1);
        chk_eq("bad12_err_cnt", 32'(err_cnt),   32'h1);
        chk_eq("bad12_valid",   32'(out_valid), 32'h0);
        sel = 4'd15;
        step();
        chk_eq("bad15_sel_err", 32'(sel_err),   32'h1);
        chk_eq("bad15_err_cnt", 32'(err_cnt),   32'h2);
        chk_eq("bad15_valid",   32'(out_valid), 32'h0);
        req_valid = 1'b0;
        step();
        chk_eq("bad_pulse_end", 32'(sel_err), 32'h0);
        chk_eq("bad_cnt_hold",  32'(err_cnt), 32'h2);
        req_valid = 1'b1; sel = 4'd12;
        for (int k = 0; k < 300; k++) step();
        chk_eq("bad_cnt_sat", 32'(err_cnt), 32'hFF);
        req_valid = 1'b0;
        step();

        // Round-robin scan; sel is out of range but must be ignored
        mode = 1'b1; req_valid = 1'b1; out_ready = 1'b1; sel = 4'd12;
        for (int k = 0; k < 12; k++) begin
            step();
            chk_eq("rr_src",     32'(out_src),   32'(k % 10));
            chk_eq("rr_data",    32'(out_data),  32'(16'h1000 + (k % 10)));
            chk_eq("rr_valid",   32'(out_valid), 32'h1);
            chk_eq("rr_no_err",  32'(sel_err),   32'h0);
        end
        chk_eq("rr_cnt_sat", 32'(err_cnt), 32'hFF);
        mode = 1'b0; req_valid = 1'b0;
        step();
        mode = 1'b1; req_valid = 1'b1;
        step();
        chk_eq("rr_restart_src",  32'(out_src),  32'h0);
        chk_eq("rr_restart_data", 32'(out_data), 32'h1000);
        step();
        chk_eq("rr_restart_next", 32'(out_src), 32'h1);

        // Streaming: consume and accept on the same edge
        mode = 1'b0;
        sel = 4'd1;
        #1;
        chk_eq("str_ready0", 32'(req_ready), 32'h1);
        step();
        chk_eq("str_data1",  32'(out_data),  32'h1001);
        chk_eq("str_valid1", 32'(out_valid), 32'h1);
        sel = 4'd8;
        step();
        chk_eq("str_data8",  32'(out_data),  32'h1008);
        chk_eq("str_valid8", 32'(out_valid), 32'h1);
        sel = 4'd9;
        step();
        chk_eq("str_data9",  32'(out_data),  32'h1009);
        chk_eq("str_src9",   32'(out_src),   32'h9);

        // Reset mid-operation with a held word and err_cnt=4
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk_eq("rst2_err_cnt", 32'(err_cnt), 32'h0);
        req_valid = 1'b1; out_ready = 1'b1; sel = 4'd12;
        for (int k = 0; k < 4; k++) step();
        sel = 4'd2;
        step();
        chk_eq("pre_rst_valid", 32'(out_valid), 32'h1);
        chk_eq("pre_rst_cnt",   32'(err_cnt),   32'h4);
        chk_eq("pre_rst_data",  32'(out_data),  32'h1002);
        req_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("async_rst_valid", 32'(out_valid), 32'h0);
        chk_eq("async_rst_cnt",   32'(err_cnt),   32'h0);
        chk_eq("async_rst_data",  32'(out_data),  32'h0);
        chk_eq("async_rst_src",   32'(out_src),   32'h0);
        step();
        chk_eq("rst_hold_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1; req_valid = 1'b1; out_ready = 1'b1; sel = 4'd4;
        step();
        chk_eq("post_rst_data",  32'(out_data),  32'h1004);
        chk_eq("post_rst_valid", 32'(out_valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
